// File: rtl/uart_tx_frame_if.sv
// Handshake and serial-line bundle for uart_tx_frame: request/character in,
// done/busy status and the registered serial line out.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_start;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_done;
    logic                 o_busy;
    logic                 o_dout;

    modport master (
        output i_start,
        output i_data,
        input  o_done,
        input  o_busy,
        input  o_dout
    );

    modport slave (
        input  i_start,
        input  i_data,
        output o_done,
        output o_busy,
        output o_dout
    );
endinterface

// File: rtl/uart_tx_frame.sv
// Configurable UART transmitter: start bit, DATA_BITS LSB first, optional
// odd/even parity, 1 or 2 stop bits; all outputs come straight from flops.
module uart_tx_frame #(
    parameter int TICKS_PER_BIT = 32,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input logic          i_clk,
    input logic          i_reset,
    uart_tx_frame_if.slave tx
);

    localparam int TW = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (TICKS_PER_BIT < 2) begin : g_bad_ticks
        $error("uart_tx_frame: TICKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Each output is computed one cycle ahead so the line changes exactly on
    // the terminal-count edge without any combinational path to the pins.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tick_last = (tick_q == TICK_LAST);

        if (state_q != S_IDLE && state_q != S_DONE) begin
            tick_d = tick_last ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                dout_d = 1'b1;
                busy_d = 1'b0;
                if (tx.i_start) begin
                    shreg_d = tx.i_data;
                    par_d   = (PARITY_MODE == 1) ? ~^tx.i_data : ^tx.i_data;
                    state_d = S_START;
                    dout_d  = 1'b0;
                    busy_d  = 1'b1;
                    tick_d  = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            S_START: begin
                if (tick_last) begin
                    state_d = S_DATA;
                    dout_d  = shreg_q[0];
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_MODE != 0) begin
                            state_d = S_PARITY;
                            dout_d  = par_q;
                        end else begin
                            state_d = S_STOP;
                            dout_d  = 1'b1;
                        end
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        dout_d  = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick_last) begin
                    state_d = S_STOP;
                    dout_d  = 1'b1;
                end
            end
            S_STOP: begin
                if (tick_last) begin
                    if (STOP_BITS == 2 && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        dout_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                dout_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx.o_dout = dout_q;
    assign tx.o_busy = busy_q;
    assign tx.o_done = done_q;

endmodule
